yarvi_trace_buf: RTL and testbench

YARVI_TRACE_BUF -- requirements
Module: yarvi_trace_buf

---
 rtl/yarvi_trace_buf.sv | 148 ++++++++++++++
 tb/tb_yarvi_trace_buf.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/yarvi_trace_buf.sv
// Retired-instruction trace buffer: circular capture store with trigger, post-trigger
// window and an oldest-first valid/ready readout once frozen.
module yarvi_trace_buf #(
  parameter int unsigned XLEN      = 64,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned POST_TRIG = 4,
  localparam int unsigned PW       = $clog2(DEPTH),
  localparam int unsigned CW       = PW + 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            arm,
  input  logic            clear,
  input  logic            trig,
  input  logic            trig_pc_en,
  input  logic [XLEN-1:0] trig_pc,
  input  logic            valid,
  input  logic [XLEN-1:0] pc,
  input  logic [31:0]     insn,
  input  logic            we,
  input  logic [4:0]      addr,
  input  logic [XLEN-1:0] d,
  output logic            rd_valid,
  input  logic            rd_ready,
  output logic [31:0]     rd_ts,
  output logic [XLEN-1:0] rd_pc,
  output logic [31:0]     rd_insn,
  output logic            rd_we,
  output logic [4:0]      rd_addr,
  output logic [XLEN-1:0] rd_d,
  output logic [1:0]      state,
  output logic [CW-1:0]   count,
  output logic            wrapped
);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StArmed  = 2'd1,
    StTrig   = 2'd2,
    StFrozen = 2'd3
  } state_e;

  state_e          r_state;
  logic [31:0]     r_ts;
  logic [PW-1:0]   r_wr_ptr;
  logic [CW-1:0]   r_count;
  logic            r_wrapped;
  logic [CW-1:0]   r_post;

  logic [31:0]     r_mem_ts   [DEPTH];
  logic [XLEN-1:0] r_mem_pc   [DEPTH];
  logic [31:0]     r_mem_insn [DEPTH];
  logic            r_mem_we   [DEPTH];
  logic [4:0]      r_mem_addr [DEPTH];
  logic [XLEN-1:0] r_mem_d    [DEPTH];

  logic            w_capture;
  logic            w_fire;
  logic            w_xfer;
  logic            w_full;
  logic [PW-1:0]   w_rd_ptr;

  assign w_capture = !clear && valid && (r_state == StArmed || r_state == StTrig);
  assign w_fire    = (r_state == StArmed) && (trig || (trig_pc_en && valid && pc == trig_pc));
  assign w_xfer    = rd_valid && rd_ready;
  assign w_full    = (r_count == CW'(DEPTH));
  // Oldest entry sits count slots behind the write pointer; it advances as count drains.
  assign w_rd_ptr  = PW'(CW'(r_wr_ptr) - r_count);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= StIdle;
      r_ts      <= 32'd0;
      r_wr_ptr  <= '0;
      r_count   <= '0;
      r_wrapped <= 1'b0;
      r_post    <= '0;
    end else begin
      r_ts <= r_ts + 32'd1;
      if (clear) begin
        r_state   <= StIdle;
        r_count   <= '0;
        r_wrapped <= 1'b0;
        r_post    <= '0;
      end else begin
        if (w_capture) begin
          r_wr_ptr <= r_wr_ptr + PW'(1);
          if (w_full) r_wrapped <= 1'b1;
          else        r_count   <= r_count + CW'(1);
        end
        unique case (r_state)
          StIdle: begin
            if (arm) begin
              r_state   <= StArmed;
              r_wr_ptr  <= '0;
              r_count   <= '0;
              r_wrapped <= 1'b0;
            end
          end
          StArmed: begin
            if (w_fire) begin
              r_post  <= CW'(POST_TRIG);
              r_state <= (POST_TRIG == 0) ? StFrozen : StTrig;
            end
          end
          StTrig: begin
            if (valid) begin
              r_post <= r_post - CW'(1);
              if (r_post == CW'(1)) r_state <= StFrozen;
            end
          end
          StFrozen: begin
            if (r_count == '0) begin
              r_state <= StIdle;
            end else if (w_xfer) begin
              r_count <= r_count - CW'(1);
              if (r_count == CW'(1)) r_state <= StIdle;
            end
          end
        endcase
      end
    end
  end

  // Trace store is deliberately not reset.
  always_ff @(posedge clock) begin
    if (w_capture) begin
      r_mem_ts[r_wr_ptr]   <= r_ts;
      r_mem_pc[r_wr_ptr]   <= pc;
      r_mem_insn[r_wr_ptr] <= insn;
      r_mem_we[r_wr_ptr]   <= we;
      r_mem_addr[r_wr_ptr] <= addr;
      r_mem_d[r_wr_ptr]    <= d;
    end
  end

  assign rd_valid = (r_state == StFrozen) && (r_count != '0);
  assign rd_ts    = r_mem_ts[w_rd_ptr];
  assign rd_pc    = r_mem_pc[w_rd_ptr];
  assign rd_insn  = r_mem_insn[w_rd_ptr];
  assign rd_we    = r_mem_we[w_rd_ptr];
  assign rd_addr  = r_mem_addr[w_rd_ptr];
  assign rd_d     = r_mem_d[w_rd_ptr];
  assign state    = r_state;
  assign count    = r_count;
  assign wrapped  = r_wrapped;

endmodule

// File: tb/tb_yarvi_trace_buf.sv
// Directed bench: instance a (DEPTH=8, POST_TRIG=2) and instance b (DEPTH=8, POST_TRIG=0)
// share stimulus; each only records once its own arm is pulsed.
module tb_yarvi_trace_buf;
  localparam int unsigned XLEN = 64;

  logic            clock = 1'b0;
  logic            reset;
  logic            arm_a, arm_b, clear, trig, trig_pc_en, valid, we, rd_ready;
  logic [XLEN-1:0] trig_pc, pc, d;
  logic [31:0]     insn;
  logic [4:0]      addr;

  logic            rd_valid_a, rd_we_a, wrapped_a;
  logic [31:0]     rd_ts_a, rd_insn_a;
  logic [XLEN-1:0] rd_pc_a, rd_d_a;
  logic [4:0]      rd_addr_a;
  logic [1:0]      state_a;
  logic [3:0]      count_a;

  logic            rd_valid_b, rd_we_b, wrapped_b;
  logic [31:0]     rd_ts_b, rd_insn_b;
  logic [XLEN-1:0] rd_pc_b, rd_d_b;
  logic [4:0]      rd_addr_b;
  logic [1:0]      state_b;
  logic [3:0]      count_b;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] tb_ts;
  logic [31:0] exp_ts [16];
  logic        pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  always #5 clock = ~clock;

  // Reference timestamp: counts every cycle since reset.
  always @(posedge clock or posedge reset) begin
    if (reset) tb_ts <= 32'd0;
    else       tb_ts <= tb_ts + 32'd1;
  end

  yarvi_trace_buf #(.XLEN(XLEN), .DEPTH(8), .POST_TRIG(2)) u_dut_a (
    .clock(clock), .reset(reset), .arm(arm_a), .clear(clear), .trig(trig),
    .trig_pc_en(trig_pc_en), .trig_pc(trig_pc), .valid(valid), .pc(pc), .insn(insn),
    .we(we), .addr(addr), .d(d), .rd_valid(rd_valid_a), .rd_ready(rd_ready),
    .rd_ts(rd_ts_a), .rd_pc(rd_pc_a), .rd_insn(rd_insn_a), .rd_we(rd_we_a),
    .rd_addr(rd_addr_a), .rd_d(rd_d_a), .state(state_a), .count(count_a),
    .wrapped(wrapped_a)
  );

  yarvi_trace_buf #(.XLEN(XLEN), .DEPTH(8), .POST_TRIG(0)) u_dut_b (
    .clock(clock), .reset(reset), .arm(arm_b), .clear(clear), .trig(trig),
    .trig_pc_en(trig_pc_en), .trig_pc(trig_pc), .valid(valid), .pc(pc), .insn(insn),
    .we(we), .addr(addr), .d(d), .rd_valid(rd_valid_b), .rd_ready(rd_ready),
    .rd_ts(rd_ts_b), .rd_pc(rd_pc_b), .rd_insn(rd_insn_b), .rd_we(rd_we_b),
    .rd_addr(rd_addr_b), .rd_d(rd_d_b), .state(state_b), .count(count_b),
    .wrapped(wrapped_b)
  );

  function automatic logic [31:0] f_insn(input logic [XLEN-1:0] p);
    return 32'hC0DE_0000 ^ p[31:0];
  endfunction
  function automatic logic [XLEN-1:0] f_d(input logic [XLEN-1:0] p);
    return {p[31:0], ~p[31:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drv(input logic v, input logic [XLEN-1:0] p);
    valid = v;
    pc    = p;
    insn  = f_insn(p);
    we    = p[2];
    addr  = p[6:2];
    d     = f_d(p);
  endtask

  initial begin
    int idx;
    int k;
    reset = 1'b1; arm_a = 1'b0; arm_b = 1'b0; clear = 1'b0; trig = 1'b0;
    trig_pc_en = 1'b0; trig_pc = '0; rd_ready = 1'b0;
    drv(1'b0, '0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    chk("reset_state", 64'(state_a), 64'd0);
    chk("reset_count", 64'(count_a), 64'd0);
    chk("reset_rd_valid", 64'(rd_valid_a), 64'd0);
    chk("reset_state_b", 64'(state_b), 64'd0);
    step();
    chk("idle_hold", 64'(state_a), 64'd0);

    // Arm with a valid entry in the same cycle: not captured.
    arm_a = 1'b1; drv(1'b1, 64'h500);
    step();
    arm_a = 1'b0; drv(1'b0, '0);
    chk("armed_state", 64'(state_a), 64'd1);
    chk("arm_cycle_nocap", 64'(count_a), 64'd0);

    // pc match with valid=0 must not fire.
    trig_pc_en = 1'b1; trig_pc = 64'h108; drv(1'b0, 64'h108);
    step();
    chk("pcmatch_novalid_state", 64'(state_a), 64'd1);
    chk("pcmatch_novalid_count", 64'(count_a), 64'd0);

    for (int i = 0; i < 5; i++) begin
      drv(1'b1, 64'h100 + 64'(4 * i));
      exp_ts[i] = tb_ts;
      step();
      chk("cap_count", 64'(count_a), 64'(i + 1));
      chk("cap_state", 64'(state_a), (i < 2) ? 64'd1 : (i < 4) ? 64'd2 : 64'd3);
    end
    drv(1'b0, '0); trig_pc_en = 1'b0;
    chk("a_wrapped", 64'(wrapped_a), 64'd0);

    rd_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("a_rd_valid", 64'(rd_valid_a), 64'd1);
      chk("a_rd_pc", rd_pc_a, 64'h100 + 64'(4 * i));
      chk("a_rd_insn", 64'(rd_insn_a), 64'(f_insn(64'h100 + 64'(4 * i))));
      chk("a_rd_d", rd_d_a, f_d(64'h100 + 64'(4 * i)));
      chk("a_rd_we", 64'(rd_we_a), 64'(i % 2));
      chk("a_rd_addr", 64'(rd_addr_a), 64'((32'h100 + 32'(4 * i)) >> 2) & 64'h1F);
      chk("a_rd_ts", 64'(rd_ts_a), 64'(exp_ts[i]));
      chk("a_rd_count", 64'(count_a), 64'(5 - i));
      step();
    end
    rd_ready = 1'b0;
    chk("a_idle_after_read", 64'(state_a), 64'd0);
    chk("a_rd_valid_after", 64'(rd_valid_a), 64'd0);

    // POST_TRIG=0 build with wrap; trig also hits idle instance a.
    arm_b = 1'b1;
    step();
    arm_b = 1'b0;
    chk("b_armed", 64'(state_b), 64'd1);
    for (int i = 0; i < 12; i++) begin
      drv(1'b1, 64'(4 * i));
      trig = (i == 11);
      exp_ts[i] = tb_ts;
      step();
    end
    trig = 1'b0; drv(1'b0, '0);
    chk("b_frozen", 64'(state_b), 64'd3);
    chk("b_count", 64'(count_b), 64'd8);
    chk("b_wrapped", 64'(wrapped_b), 64'd1);
    chk("idle_trig_ignored", 64'(state_a), 64'd0);

    idx = 0;
    k = 0;
    while (idx < 8 && k < 60) begin
      chk("b_rd_valid", 64'(rd_valid_b), 64'd1);
      chk("b_rd_pc", rd_pc_b, 64'h10 + 64'(4 * idx));
      chk("b_rd_ts", 64'(rd_ts_b), 64'(exp_ts[idx + 4]));
      chk("b_rd_count", 64'(count_b), 64'(8 - idx));
      if (idx > 0) chk("b_ts_step", 64'(rd_ts_b - exp_ts[idx + 3]), 64'd1);
      rd_ready = pat[k % 6];
      if (rd_ready) idx++;
      step();
      k++;
    end
    rd_ready = 1'b0;
    chk("b_read_budget", 64'(idx), 64'd8);
    chk("b_idle_after_read", 64'(state_b), 64'd0);
    chk("b_rd_valid_after", 64'(rd_valid_b), 64'd0);

    // Clear mid-readout, with rd_ready held high in the clear cycle.
    arm_a = 1'b1;
    step();
    arm_a = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drv(1'b1, 64'h200 + 64'(4 * i));
      trig = (i == 2);
      step();
    end
    trig = 1'b0; drv(1'b0, '0);
    chk("c_frozen", 64'(state_a), 64'd3);
    chk("c_count", 64'(count_a), 64'd5);
    rd_ready = 1'b1;
    step();
    step();
    chk("c_count_after2", 64'(count_a), 64'd3);
    clear = 1'b1;
    step();
    clear = 1'b0; rd_ready = 1'b0;
    chk("clear_state", 64'(state_a), 64'd0);
    chk("clear_rd_valid", 64'(rd_valid_a), 64'd0);
    chk("clear_count", 64'(count_a), 64'd0);

    // Asynchronous reset while TRIGGERED.
    arm_a = 1'b1;
    step();
    arm_a = 1'b0;
    drv(1'b1, 64'h300); trig = 1'b1;
    step();
    trig = 1'b0; drv(1'b0, '0);
    chk("pre_reset_state", 64'(state_a), 64'd2);
    chk("pre_reset_count", 64'(count_a), 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_state", 64'(state_a), 64'd0);
    chk("async_reset_count", 64'(count_a), 64'd0);
    chk("async_reset_rd_valid", 64'(rd_valid_a), 64'd0);
    step();
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
